ws2812b_rx: RTL and testbench

//  Receiver/decoder for the WS2812B single-wire LED protocol: samples the LED data line, decodes
//  NRZ-pulse bits into 24-bit GRB pixel words, buffers them in a FIFO, exposes them on the softcore

---
 rtl/ws2812b_rx.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ws2812b_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B line receiver: decodes NRZ pulses into 24-bit GRB words, queues them in a FIFO
// and exposes DATA/STATUS/CTRL on the memory bus. Optional irq output with WS2812B_RX_IRQ_EN.
`timescale 1ns/1ps
module ws2812b_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int T_BIT_NS   = 600,
    parameter int T_MIN_NS   = 100,
    parameter int T_MAX_NS   = 2000,
    parameter int T_RES_NS   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [10:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    input  logic        din
`ifdef WS2812B_RX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam longint NS_PER_S  = 64'sd1000000000;
    localparam longint CLK_L     = longint'(CLK_FREQ);
    localparam int     T_BIT_CYC = int'((longint'(T_BIT_NS) * CLK_L) / NS_PER_S);
    localparam int     T_MIN_CYC = int'((longint'(T_MIN_NS) * CLK_L) / NS_PER_S);
    localparam int     T_MAX_CYC = int'((longint'(T_MAX_NS) * CLK_L) / NS_PER_S);
    localparam int     T_RES_CYC = int'((longint'(T_RES_NS) * CLK_L) / NS_PER_S);
    localparam int     CNT_TOP   = ((T_RES_CYC > T_MAX_CYC) ? T_RES_CYC : T_MAX_CYC) + 2;
    localparam int     CNT_W     = $clog2(CNT_TOP);
    localparam int     AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int     CW        = AW + 1;

    localparam logic [CNT_W-1:0] BIT_TH  = CNT_W'(T_BIT_CYC);
    localparam logic [CNT_W-1:0] MIN_TH  = CNT_W'(T_MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_TH  = CNT_W'(T_MAX_CYC);
    localparam logic [CNT_W-1:0] RES_TH  = CNT_W'(T_RES_CYC);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    logic             sync1_q, sync2_q, prev_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [23:0]      shreg_q, shreg_d;
    logic             push_q, push_d;
    logic [23:0]      pword_q, pword_d;
    logic             word_seen_q, word_seen_d;
    logic             set_err_s, set_frame_s;
    logic             rise_s, fall_s, gap_s, bit_s;

    logic [23:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_s, empty_s, push_ok_s, ovf_set_s, pop_s;
    logic [31:0]      count32_s;
    logic [7:0]       count8_s;

    logic             ready_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             enable_q, enable_d;
    logic             overflow_q, bit_err_q, frame_done_q;
    logic [2:0]       clr_s;
    logic             access_s, is_rd_s;
    logic [31:0]      status_s, ctrl_s;
`ifdef WS2812B_RX_IRQ_EN
    logic             irq_en_q, irq_en_d, irq_q;
    logic             unused_s;
    assign unused_s = ^{addr[10:4], addr[1:0], wdata[31:5]};
`else
    logic             unused_s;
    assign unused_s = ^{addr[10:4], addr[1:0], wdata[31:5], wdata[1]};
`endif

    assign rise_s = sync2_q & ~prev_q;
    assign fall_s = ~sync2_q & prev_q;
    // A gap needs a settled low line; prev_q excludes the falling-edge cycle of a long high.
    assign gap_s  = ~sync2_q & ~prev_q & (cnt_q >= RES_TH);
    assign bit_s  = (cnt_q > BIT_TH);

    // Decoder FSM next state, bit assembly and flag events
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        push_d      = 1'b0;
        pword_d     = pword_q;
        word_seen_d = word_seen_q;
        set_err_s   = 1'b0;
        set_frame_s = 1'b0;
        if (rise_s || fall_s) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (enable_q) begin
            case (state_q)
                S_SYNC: begin
                    if (gap_s) state_d = S_IDLE;
                    else       state_d = S_SYNC;
                end
                S_IDLE: begin
                    if (rise_s) begin
                        state_d = S_HIGH;
                    end else if (gap_s && bitcnt_q != 5'd0) begin
                        set_err_s = 1'b1;
                        bitcnt_d  = 5'd0;
                    end else if (gap_s && word_seen_q) begin
                        set_frame_s = 1'b1;
                        word_seen_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HIGH: begin
                    if (fall_s && cnt_q < MIN_TH) begin
                        set_err_s = 1'b1;
                        bitcnt_d  = 5'd0;
                        state_d   = S_SYNC;
                    end else if (fall_s) begin
                        shreg_d = {shreg_q[22:0], bit_s};
                        state_d = S_IDLE;
                        if (bitcnt_q == 5'd23) begin
                            push_d      = 1'b1;
                            pword_d     = {shreg_q[22:0], bit_s};
                            bitcnt_d    = 5'd0;
                            word_seen_d = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end else if (cnt_q > MAX_TH) begin
                        set_err_s = 1'b1;
                        bitcnt_d  = 5'd0;
                        state_d   = S_SYNC;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
                default: begin
                    state_d  = S_SYNC;
                    bitcnt_d = 5'd0;
                end
            endcase
        end else begin
            state_d  = S_SYNC;
            bitcnt_d = 5'd0;
        end
    end

    // Synchroniser, edge register and decoder state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= S_SYNC;
            cnt_q       <= {CNT_W{1'b0}};
            bitcnt_q    <= 5'd0;
            shreg_q     <= 24'd0;
            push_q      <= 1'b0;
            pword_q     <= 24'd0;
            word_seen_q <= 1'b0;
        end else begin
            sync1_q     <= din;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            pword_q     <= pword_d;
            word_seen_q <= word_seen_d;
        end
    end

    assign full_s    = (count_q == CW'(FIFO_DEPTH));
    assign empty_s   = (count_q == {CW{1'b0}});
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok_s = push_q & (~full_s | pop_s);
    assign ovf_set_s = push_q & full_s & ~pop_s;
    assign count32_s = 32'(count_q);
    assign count8_s  = (count32_s > 32'd255) ? 8'hFF : count32_s[7:0];

    // FIFO occupancy next value
    always_comb begin
        if (push_ok_s && !pop_s) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_ok_s) begin
            count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wptr_q] <= pword_q;
        end
    end

    assign status_s = {16'd0, count8_s, 3'd0, frame_done_q, bit_err_q, overflow_q, full_s, empty_s};
`ifdef WS2812B_RX_IRQ_EN
    assign ctrl_s   = {30'd0, irq_en_q, enable_q};
`else
    assign ctrl_s   = {31'd0, enable_q};
`endif
    assign access_s = sel & ~ready_q;
    assign is_rd_s  = (wstrb == 4'b0000);

    // Bus decode: one side effect per select assertion
    always_comb begin
        rdata_d  = rdata_q;
        pop_s    = 1'b0;
        clr_s    = 3'b000;
        enable_d = enable_q;
`ifdef WS2812B_RX_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (access_s) begin
            case (addr[3:2])
                2'd0: begin
                    if (is_rd_s && !empty_s) begin
                        rdata_d = {1'b1, 7'd0, mem_q[rptr_q]};
                        pop_s   = 1'b1;
                    end else begin
                        rdata_d = 32'd0;
                    end
                end
                2'd1: begin
                    rdata_d = is_rd_s ? status_s : 32'd0;
                    if (wstrb[0]) clr_s = wdata[4:2];
                    else          clr_s = 3'b000;
                end
                2'd2: begin
                    rdata_d = is_rd_s ? ctrl_s : 32'd0;
                    if (wstrb[0]) begin
                        enable_d = wdata[0];
`ifdef WS2812B_RX_IRQ_EN
                        irq_en_d = wdata[1];
`endif
                    end else begin
                        enable_d = enable_q;
                    end
                end
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // FIFO pointers, flags and bus registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q       <= {AW{1'b0}};
            rptr_q       <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            overflow_q   <= 1'b0;
            bit_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= 32'd0;
            enable_q     <= 1'b1;
        end else begin
            if (push_ok_s) wptr_q <= wptr_q + {{(AW-1){1'b0}}, 1'b1};
            if (pop_s)     rptr_q <= rptr_q + {{(AW-1){1'b0}}, 1'b1};
            count_q      <= count_d;
            overflow_q   <= ovf_set_s   | (overflow_q   & ~clr_s[0]);
            bit_err_q    <= set_err_s   | (bit_err_q    & ~clr_s[1]);
            frame_done_q <= set_frame_s | (frame_done_q & ~clr_s[2]);
            ready_q      <= sel;
            rdata_q      <= rdata_d;
            enable_q     <= enable_d;
        end
    end

`ifdef WS2812B_RX_IRQ_EN
    // Interrupt enable and registered interrupt output
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & (frame_done_q | overflow_q);
        end
    end
    assign irq = irq_q;
`endif

    assign rdata = rdata_q;
    assign ready = ready_q;
endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: drives WS2812B waveforms on din and checks the bus registers.
`timescale 1ns/1ps
module tb_ws2812b_rx;
    logic        clk = 1'b0;
    logic        reset, sel, din, ready;
    logic [10:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata, rdata;
    int          checks = 0;
    int          failures = 0;
`ifdef WS2812B_RX_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    ws2812b_rx dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .wstrb (wstrb),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .din   (din)
`ifdef WS2812B_RX_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    task automatic bus(input logic [10:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        @(negedge clk);
        sel = 1'b1; addr = a; wstrb = s; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < 16);
        if (ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL bus_timeout addr=%h ready=%b required 1", a, ready);
        end
        r = rdata;
        sel = 1'b0; wstrb = 4'h0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [10:0] a, output logic [31:0] r);
        bus(a, 4'h0, 32'h0, r);
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 4'h1, d, r);
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        if (b) #800; else #400;
        din = 1'b0;
        if (b) #450; else #850;
    endtask

    task automatic send_bits(input int n, input logic [23:0] v);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(24, w);
    endtask

    task automatic gap();
        din = 1'b0;
        #60000;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        reset = 1'b0;
        rd(11'h004, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL rst_status got=%h exp=00000001", r); end
        rd(11'h008, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL rst_ctrl got=%h exp=00000001", r); end
        rd(11'h00C, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_reg_c got=%h exp=0", r); end
        rd(11'h000, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", r); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        gap(); send_word(24'h80CF80); gap();
        rd(11'h004, r);
        checks++; if (r !== 32'h00000110) begin failures++; $display("FAIL t1_status got=%h exp=00000110", r); end
        rd(11'h000, r);
        checks++; if (r !== 32'h8080CF80) begin failures++; $display("FAIL t1_data got=%h exp=8080CF80", r); end
        rd(11'h004, r);
        checks++; if (r !== 32'h00000011) begin failures++; $display("FAIL t1_status2 got=%h exp=00000011", r); end
        wr(11'h004, 32'h1C);
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        for (int w = 1; w <= 9; w++) send_word(24'(w));
        gap();
        rd(11'h004, r);
        checks++; if (r !== 32'h00000816) begin failures++; $display("FAIL t2_status got=%h exp=00000816", r); end
        for (int i = 1; i <= 8; i++) begin
            rd(11'h000, r);
            checks++;
            if (r !== (32'h80000000 | 32'(i))) begin
                failures++; $display("FAIL t2_data%0d got=%h exp=%h", i, r, 32'h80000000 | 32'(i));
            end
        end
        rd(11'h000, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL t2_empty_data got=%h exp=0", r); end
        rd(11'h004, r);
        checks++; if (r !== 32'h00000015) begin failures++; $display("FAIL t2_status2 got=%h exp=00000015", r); end
        wr(11'h004, 32'h1C);
        rd(11'h004, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL t2_w1c got=%h exp=00000001", r); end
    endtask

    task automatic test_partial_frame();
        logic [31:0] r;
        send_bits(10, 24'h2A5); gap();
        rd(11'h004, r);
        checks++; if (r !== 32'h00000009) begin failures++; $display("FAIL t3_status got=%h exp=00000009", r); end
        wr(11'h004, 32'h1C);
        rd(11'h004, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL t3_w1c got=%h exp=00000001", r); end
    endtask

    task automatic test_glitch_stuck();
        logic [31:0] r;
        send_bits(5, 24'h15);
        din = 1'b1; #50; din = 1'b0; #1000;
        rd(11'h004, r);
        checks++; if (r !== 32'h00000009) begin failures++; $display("FAIL t4_glitch got=%h exp=00000009", r); end
        wr(11'h004, 32'h1C);
        gap();
        send_bits(3, 24'h5);
        din = 1'b1; #3000; din = 1'b0; #1000;
        rd(11'h004, r);
        checks++; if (r !== 32'h00000009) begin failures++; $display("FAIL t4_stuck got=%h exp=00000009", r); end
        wr(11'h004, 32'h1C);
        gap(); send_word(24'hFFFFFF); gap();
        rd(11'h004, r);
        checks++; if (r !== 32'h00000110) begin failures++; $display("FAIL t4_status got=%h exp=00000110", r); end
        rd(11'h000, r);
        checks++; if (r !== 32'h80FFFFFF) begin failures++; $display("FAIL t4_data got=%h exp=80FFFFFF", r); end
        wr(11'h004, 32'h1C);
    endtask

    task automatic test_held_select();
        logic [31:0] r;
        logic        exp_rdy;
        send_word(24'h123456); send_word(24'hABCDEF);
        din = 1'b0; #1000;
        @(negedge clk);
        sel = 1'b1; addr = 11'h000; wstrb = 4'h0; wdata = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            exp_rdy = (i >= 2);
            checks++;
            if (ready !== exp_rdy) begin failures++; $display("FAIL t5_ready_c%0d got=%b exp=%b", i, ready, exp_rdy); end
        end
        checks++; if (rdata !== 32'h80123456) begin failures++; $display("FAIL t5_rdata got=%h exp=80123456", rdata); end
        sel = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL t5_ready_off got=%b exp=0", ready); end
        rd(11'h004, r);
        checks++; if (r !== 32'h00000100) begin failures++; $display("FAIL t5_one_pop got=%h exp=00000100", r); end
        bus(11'h000, 4'hF, 32'h0, r);
        rd(11'h004, r);
        checks++; if (r !== 32'h00000100) begin failures++; $display("FAIL t5_write_no_pop got=%h exp=00000100", r); end
        rd(11'h000, r);
        checks++; if (r !== 32'h80ABCDEF) begin failures++; $display("FAIL t5_data2 got=%h exp=80ABCDEF", r); end
    endtask

    task automatic test_reset_midword();
        logic [31:0] r;
        send_bits(12, 24'hA5C);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++; if (ready !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL t6_bus_rst got=%b/%h exp=0/0", ready, rdata);
        end
        rd(11'h004, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL t6_status got=%h exp=00000001", r); end
        rd(11'h008, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL t6_ctrl got=%h exp=00000001", r); end
        gap(); send_word(24'h5A3C96); gap();
        rd(11'h000, r);
        checks++; if (r !== 32'h805A3C96) begin failures++; $display("FAIL t6_data got=%h exp=805A3C96", r); end
        rd(11'h004, r);
        checks++; if (r !== 32'h00000011) begin failures++; $display("FAIL t6_status2 got=%h exp=00000011", r); end
        wr(11'h004, 32'h1C);
    endtask

    task automatic test_enable();
        logic [31:0] r;
        wr(11'h008, 32'h0);
        rd(11'h008, r);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL en_ctrl0 got=%h exp=0", r); end
        send_word(24'h111111);
        din = 1'b0; #2000;
        rd(11'h004, r);
        checks++; if (r !== 32'h00000001) begin failures++; $display("FAIL en_no_push got=%h exp=00000001", r); end
        wr(11'h008, 32'h3);
        rd(11'h008, r);
`ifdef WS2812B_RX_IRQ_EN
        checks++; if (r !== 32'h3) begin failures++; $display("FAIL en_ctrl1 got=%h exp=3", r); end
`else
        checks++; if (r !== 32'h1) begin failures++; $display("FAIL en_ctrl1 got=%h exp=1", r); end
`endif
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; din = 1'b0;
        addr = 11'h0; wstrb = 4'h0; wdata = 32'h0;
        test_reset();
        test_single_frame();
        test_overflow();
        test_partial_frame();
        test_glitch_stuck();
        test_held_select();
        test_reset_midword();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
